// File: rtl/kpn_fifo_arbiter.sv
// Occupancy-tracking controller sharing one KPN channel FIFO between N_REQ
// round-robin producers and one consumer; issues at most one FIFO op per cycle.
module kpn_fifo_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       grant,
  input  logic                   rd_req,
  output logic                   rd_valid,
  output logic                   fifo_wr,
  output logic                   fifo_rd,
  output logic [WIDTH-1:0]       fifo_entry,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_e;

  logic [IDX_W-1:0] rr_ptr;
  logic             wr_starved;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [WIDTH-1:0] win_data;
  logic             wr_ok;
  logic             rd_ok;
  op_e              op;
  logic             starved_n;
  logic [CNT_W-1:0] count_n;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && req[(int'(rr_ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = data_in[i*WIDTH +: WIDTH];
    end
  end

  assign wr_ok = win_found && (count < DEPTH_C);
  assign rd_ok = rd_req && (count != '0);

  // Under contention the two sides alternate; wr_starved remembers who lost.
  always_comb begin
    op        = OP_IDLE;
    starved_n = wr_starved;
    if (wr_ok && rd_ok) begin
      if (wr_starved) begin
        op        = OP_WRITE;
        starved_n = 1'b0;
      end else begin
        op        = OP_READ;
        starved_n = 1'b1;
      end
    end else if (wr_ok) begin
      op        = OP_WRITE;
      starved_n = 1'b0;
    end else if (rd_ok) begin
      op = OP_READ;
    end
  end

  always_comb begin
    count_n = count;
    case (op)
      OP_WRITE: count_n = count + CNT_W'(1);
      OP_READ:  count_n = count - CNT_W'(1);
      default:  count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= '0;
      rd_valid   <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_rd    <= 1'b0;
      fifo_entry <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      rr_ptr     <= IDX_W'(N_REQ - 1);
      wr_starved <= 1'b0;
    end else begin
      grant      <= '0;
      fifo_wr    <= 1'b0;
      fifo_rd    <= 1'b0;
      // FIFO output register updates on the edge ending the fifo_rd cycle.
      rd_valid   <= fifo_rd;
      count      <= count_n;
      full       <= (count_n == DEPTH_C);
      empty      <= (count_n == '0);
      wr_starved <= starved_n;
      if (op == OP_WRITE) begin
        grant      <= N_REQ'(1) << win_idx;
        fifo_wr    <= 1'b1;
        fifo_entry <= win_data;
        rr_ptr     <= win_idx;
      end
      if (op == OP_READ) begin
        fifo_rd <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kpn_fifo_arbiter.sv
// Bench for kpn_fifo_arbiter: behavioural channel FIFO, write/read scoreboards
// and directed phases for round-robin, full, empty, contention and reset.
module tb_kpn_fifo_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int CNT_W = 9;
  localparam int EW    = N_REQ + WIDTH;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       grant;
  logic                   rd_req;
  logic                   rd_valid;
  logic                   fifo_wr;
  logic                   fifo_rd;
  logic [WIDTH-1:0]       fifo_entry;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic                   empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  logic [EW-1:0]    wr_exp_q[$];
  logic [WIDTH-1:0] rd_exp_q[$];
  logic [WIDTH-1:0] fmem[$];
  logic [WIDTH-1:0] fifo_q;

  kpn_fifo_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .grant(grant),
    .rd_req(rd_req), .rd_valid(rd_valid), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .fifo_entry(fifo_entry), .count(count), .full(full), .empty(empty)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural channel FIFO with a registered output.
  always @(posedge clk) begin
    if (reset) begin
      fmem.delete();
    end else begin
      if (fifo_wr) fmem.push_back(fifo_entry);
      if (fifo_rd && fmem.size() > 0) fifo_q <= fmem.pop_front();
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      logic [EW-1:0] e;
      logic [WIDTH-1:0] r;
      check("wr_rd_excl", 32'(fifo_wr & fifo_rd), 32'd0);
      if (fifo_wr) begin
        if (wr_exp_q.size() == 0) begin
          check("wr_unexpected", 32'(fifo_wr), 32'd0);
        end else begin
          e = wr_exp_q.pop_front();
          check("wr_grant", 32'(grant), 32'(e[EW-1:WIDTH]));
          check("wr_entry", 32'(fifo_entry), 32'(e[WIDTH-1:0]));
        end
      end
      if (rd_valid) begin
        if (rd_exp_q.size() == 0) begin
          check("rd_unexpected", 32'(rd_valid), 32'd0);
        end else begin
          r = rd_exp_q.pop_front();
          check("rd_data", 32'(fifo_q), 32'(r));
        end
      end
    end
  end

  // driver tasks
  task automatic set_data(input int idx, input logic [WIDTH-1:0] v);
    data_in[idx*WIDTH +: WIDTH] = v;
  endtask

  task automatic push_wr(input int idx, input logic [WIDTH-1:0] v);
    logic [N_REQ-1:0] g;
    g = '0;
    g[idx] = 1'b1;
    wr_exp_q.push_back({g, v});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
    check({tag, "_fifo_rd"}, 32'(fifo_rd), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req    = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      rd_req = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    wr_exp_q.delete();
    rd_exp_q.delete();
    check_reset_values("reset");
    check("reset_fifo_entry", 32'(fifo_entry), 32'd0);
    req    = '0;
    rd_req = 1'b0;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic write_one(input int idx, input logic [WIDTH-1:0] v);
    logic seen;
    seen = 1'b0;
    set_data(idx, v);
    push_wr(idx, v);
    req[idx] = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = grant[idx];
    end
    check("write_one_grant_seen", 32'(seen), 32'd1);
    req[idx] = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    rd_req  = 1'b0;
    data_in = '0;
    fifo_q  = '0;
    @(posedge clk);
    #1;

    // Reset, then round-robin starting at requester 0
    do_reset();
    set_data(0, 16'h000A);
    set_data(1, 16'h000B);
    set_data(2, 16'h000C);
    set_data(3, 16'h000D);
    push_wr(0, 16'h000A);
    push_wr(1, 16'h000B);
    push_wr(2, 16'h000C);
    push_wr(3, 16'h000D);
    push_wr(0, 16'h000A);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rr_count", 32'(count), 32'(i + 1));
      check("rr_grant", 32'(grant), 32'(4'b0001 << (i % N_REQ)));
    end
    req = '0;
    @(posedge clk);
    #1;
    check("rr_idle_grant", 32'(grant), 32'd0);
    check("rr_count_hold", 32'(count), 32'd5);

    // Fill to DEPTH, then read against a still-requesting producer
    do_reset();
    set_data(0, 16'h00F0);
    for (int i = 0; i < DEPTH; i++) push_wr(0, 16'h00F0);
    req = 4'b0001;
    for (int i = 0; i < 260; i++) begin
      @(posedge clk);
      #1;
    end
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_flag", 32'(full), 32'd1);
    check("full_grant", 32'(grant), 32'd0);
    check("full_fifo_wr", 32'(fifo_wr), 32'd0);
    rd_req = 1'b1;
    rd_exp_q.push_back(16'h00F0);
    push_wr(0, 16'h00F0);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    check("full_read_fifo_rd", 32'(fifo_rd), 32'd1);
    check("full_read_fifo_wr", 32'(fifo_wr), 32'd0);
    check("full_read_count", 32'(count), 32'(DEPTH - 1));
    check("full_read_flag", 32'(full), 32'd0);
    @(posedge clk);
    #1;
    req = '0;
    check("refill_count", 32'(count), 32'(DEPTH));
    check("refill_rd_valid", 32'(rd_valid), 32'd1);
    @(posedge clk);
    #1;

    // Read while empty is ignored; then single write read back
    do_reset();
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("empty_fifo_rd", 32'(fifo_rd), 32'd0);
      check("empty_rd_valid", 32'(rd_valid), 32'd0);
    end
    rd_req = 1'b0;
    write_one(0, 16'h1234);
    rd_exp_q.push_back(16'h1234);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    check("single_fifo_rd", 32'(fifo_rd), 32'd1);
    @(posedge clk);
    #1;
    check("single_rd_valid", 32'(rd_valid), 32'd1);
    check("single_rd_data", 32'(fifo_q), 32'h1234);
    check("single_empty", 32'(empty), 32'd1);

    // Contention: read and write alternate starting with read
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      set_data(0, 16'(16'h0100 + i));
      push_wr(0, 16'(16'h0100 + i));
      @(posedge clk);
      #1;
    end
    check("cont_fill_count", 32'(count), 32'd5);
    for (int i = 0; i < 4; i++) begin
      push_wr(0, 16'(16'h0200 + i));
      rd_exp_q.push_back(16'(16'h0100 + i));
    end
    set_data(0, 16'h0200);
    rd_req = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      if (j % 2 == 0) begin
        check("cont_rd_phase_fifo_rd", 32'(fifo_rd), 32'd1);
        check("cont_rd_phase_count", 32'(count), 32'd4);
      end else begin
        check("cont_wr_phase_fifo_wr", 32'(fifo_wr), 32'd1);
        check("cont_wr_phase_count", 32'(count), 32'd5);
        set_data(0, 16'(16'h0200 + (j + 1) / 2));
      end
    end
    req    = '0;
    rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-operation with a grant in flight
    do_reset();
    set_data(0, 16'h0055);
    for (int i = 0; i < 11; i++) push_wr(0, 16'h0055);
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_count_before", 32'(count), 32'd10);
    check("mid_grant_before", 32'(grant), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("mid_reset");
    wr_exp_q.delete();
    rd_exp_q.delete();
    reset = 1'b0;
    req   = 4'b1111;
    set_data(0, 16'h0A0A);
    set_data(1, 16'h0B0B);
    push_wr(0, 16'h0A0A);
    @(posedge clk);
    #1;
    req = '0;
    check("mid_restart_grant", 32'(grant), 32'd1);
    check("mid_restart_count", 32'(count), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    check("wr_q_drained", 32'(wr_exp_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kpn_fifo_arbiter.md
Name: kpn_fifo_arbiter

Overview:
- Controller that shares one single-port-write / single-port-read KPN channel FIFO between N_REQ producer processes and one consumer process.
- The FIFO exposes no status, so this block tracks occupancy itself and is the only driver of the FIFO's wr, rd and entry_1 inputs.
- It round-robin arbitrates producer writes and gates reads. It never issues write and read in the same cycle.
- Sits between the producer processes, the channel FIFO and the consuming process in each KPN channel.

Parameters:
- N_REQ, 4, number of producer requesters (≥2).
- WIDTH, 16, token width in bits.
- DEPTH, 256, FIFO capacity in tokens.
- CNT_W, 9, occupancy counter width; must hold the value DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  producer write requests; held until granted.
- data_in  in  N_REQ*WIDTH  producer tokens; slice i = data_in[i*WIDTH +: WIDTH].
- grant  out  N_REQ  one-hot, one-cycle pulse: token from that producer accepted.
- rd_req  in  1  consumer read request; level-sensitive.
- rd_valid  out  1  one-cycle pulse: FIFO output token is valid this cycle.
- fifo_wr  out  1  to FIFO wr.
- fifo_rd  out  1  to FIFO rd.
- fifo_entry  out  WIDTH  to FIFO entry_1.
- count  out  CNT_W  tokens held (controller view).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- All outputs are registered. Reset values: grant=0, rd_valid=0, fifo_wr=0, fifo_rd=0, fifo_entry=0, count=0, full=0, empty=1. Internal state resets to rr_ptr=N_REQ-1 and wr_starved=0.
- Eligibility at each rising edge (not in reset):
  - wr_ok = (|req) && count < DEPTH
  - rd_ok = rd_req && count > 0
- Decision:
  - Only wr_ok: WRITE.
  - Only rd_ok: READ.
  - Both: if wr_starved, WRITE and clear wr_starved; else READ and set wr_starved.
  - Neither: IDLE. wr_starved is unchanged.
  - A WRITE taken without contention clears wr_starved.
- WRITE:
  - Winner is the first i with req[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - Next cycle: grant[i]=1, fifo_wr=1, fifo_entry=data_in slice i. Set rr_ptr=i and count+1.
- READ: next cycle fifo_rd=1 and count-1. rd_valid=1 the cycle after fifo_rd, aligned with the FIFO's updated output.
- Read latency: rd_req sampled at edge k gives fifo_rd high in cycle k→k+1 and rd_valid high in cycle k+1→k+2.
- Write latency: req sampled at edge k gives grant and fifo_wr in cycle k→k+1; the FIFO stores the token at edge k+1.
- IDLE: grant=0, fifo_wr=0, fifo_rd=0. fifo_entry holds its last value.
- fifo_wr and fifo_rd are never both 1 in the same cycle.
- full and empty are registered from the next-state count, so they are consistent with count in the same cycle.
- Boundaries:
  - No write when count=DEPTH; no read when count=0.
  - With count=DEPTH and both requests present, READ wins regardless of wr_starved.
  - With count=0 and both requests present, WRITE wins.
  - rr_ptr wraps from N_REQ-1 to 0.
  - count never exceeds DEPTH and never underflows.
- Grant handshake:
  - A producer may change data_in or drop req only after seeing its grant.
  - A req dropped before grant is treated as withdrawn; no token is written.
- Reset mid-operation:
  - Next edge: outputs return to reset values and in-flight grant and rd_valid pulses are cancelled.
  - The system resets the channel FIFO alongside this block; any tokens held are discarded.

Test Plan:
- Reset: hold reset 3 cycles with random req and rd_req -> all outputs at reset values, empty=1, count=0; the first grant after release goes to requester 0.
- Round-robin: N_REQ=4, req=4'b1111 held, data_in slices 0x000A/0x000B/0x000C/0x000D, rd_req=0 -> grant 0001, 0010, 0100, 1000, 0001 on consecutive cycles; fifo_entry 0x000A, 0x000B, 0x000C, 0x000D, 0x000A; count 1 to 5.
- Full: req=0001 held for 260 cycles -> exactly 256 fifo_wr pulses; count=256 and full=1, then grant=0 and fifo_wr=0. Then rd_req=1 -> fifo_rd=1, count=255, full=0.
- Empty read: count=0, rd_req=1 for 5 cycles, req=0 -> fifo_rd and rd_valid stay 0. Then a single write, value 0x1234, read back -> rd_valid pulses two cycles after the rd_req sample, with FIFO output 0x1234.
- Contention: count=5, req=0001 and rd_req=1 held -> fifo_rd, fifo_wr, fifo_rd, fifo_wr… alternating; fifo_wr and fifo_rd never both 1; count oscillates 4, 5, 4, 5.
- Mid-operation reset: reset asserted for one cycle while count=10 and a grant is pending -> next cycle grant=0, count=0, empty=1; after release, arbitration restarts at requester 0.
